// File: rtl/alu_result_sink.sv
// alu_result_sink: consumes ALU results one handshake at a time.
// MUL/DIV results are written to HI/LO. All other results with a non-zero
// destination are queued in a 2-entry write-back FIFO. ALU flags are latched.
// Optional feature macro: STICKY_V_EN (sticky overflow bit, cleared by clr_sticky).
module alu_result_sink #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  FS,
   input  logic [4:0]  dest,
   input  logic [31:0] Y_hi,
   input  logic [31:0] Y_lo,
   input  logic        C,
   input  logic        V,
   input  logic        N,
   input  logic        Z,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_dest,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q,
   output logic [3:0]  flags_q,
   input  logic        clr_sticky,
   output logic        sticky_v
);

   // Full level for the 2-bit occupancy counter.
   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   logic [31:0] data_q [2];
   logic [4:0]  dst_q  [2];
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] hi_d, lo_d;
   logic [3:0]  flags_d;

   logic accept;
   logic is_muldiv;
   logic push;
   logic pop;

   // Handshake status depends on occupancy only, never on in_valid or wb_ready.
   assign in_ready  = (count_q != FULL_CNT);
   assign wb_valid  = (count_q != 2'd0);
   assign wb_data   = data_q[rd_ptr_q];
   assign wb_dest   = dst_q[rd_ptr_q];

   // FS 5'h1E (MUL) and 5'h1F (DIV) share the upper four bits.
   assign is_muldiv = (FS[4:1] == 4'hF);
   assign accept    = in_valid && in_ready;
   // Writes to r0 are architecturally discarded, so they never occupy the FIFO.
   assign push      = accept && !is_muldiv && (dest != 5'd0);
   assign pop       = wb_valid && wb_ready;

   // Next-state for FIFO pointers/count and architectural HI/LO/flags.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      flags_d  = flags_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (accept) begin
         if (is_muldiv) begin
            hi_d         = Y_hi;
            lo_d         = Y_lo;
            // C and V are don't-care from the ALU for MUL/DIV; keep prior values.
            flags_d[1:0] = {N, Z};
         end else begin
            flags_d      = {C, V, N, Z};
         end
      end
   end

   // Control and architectural state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         flags_q  <= 4'b0000;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         flags_q  <= flags_d;
      end
   end

   // FIFO storage; cleared on reset so the head reads zero afterwards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= 32'd0;
            dst_q[i]  <= 5'd0;
         end
      end else if (push) begin
         data_q[wr_ptr_q] <= Y_lo;
         dst_q[wr_ptr_q]  <= dest;
      end
   end

`ifdef STICKY_V_EN
   logic sticky_q, sticky_d;

   // A new overflow takes priority over a clear in the same cycle.
   always_comb begin
      sticky_d = sticky_q;
      if (clr_sticky) begin
         sticky_d = 1'b0;
      end
      if (accept && !is_muldiv && V) begin
         sticky_d = 1'b1;
      end
   end

   // Sticky overflow register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky_v = sticky_q;
`else
   logic unused_clr_sticky;
   assign unused_clr_sticky = clr_sticky;
   assign sticky_v          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_sink.sv
// Scoreboard bench for alu_result_sink.
module tb_alu_result_sink;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  FS;
   logic [4:0]  dest;
   logic [31:0] Y_hi;
   logic [31:0] Y_lo;
   logic        C, V, N, Z;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_dest;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [3:0]  flags_q;
   logic        clr_sticky;
   logic        sticky_v;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   int cycles = 0;
   logic [36:0] exp_q [$];

   alu_result_sink #(.DEPTH(2)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .FS(FS), .dest(dest), .Y_hi(Y_hi), .Y_lo(Y_lo),
      .C(C), .V(V), .N(N), .Z(Z),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest),
      .hi_q(hi_q), .lo_q(lo_q), .flags_q(flags_q),
      .clr_sticky(clr_sticky), .sticky_v(sticky_v)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycles <= cycles + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write-back handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset && wb_valid && wb_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected", 32'd1, 32'd0);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("sb_data", wb_data, e[36:5]);
            check("sb_dest", 32'(wb_dest), 32'(e[4:0]));
            pops++;
         end
      end
   end

   // Presents one result and returns just after the accepting edge, in_valid still high.
   task automatic send(input logic [4:0] fs, input logic [4:0] d,
                       input logic [31:0] yh, input logic [31:0] yl, input logic [3:0] f);
      int n;
      FS = fs; dest = d; Y_hi = yh; Y_lo = yl; {C, V, N, Z} = f;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         check("send_timeout", 32'd0, 32'd1);
      end else if (fs[4:1] != 4'hF && d != 5'd0) begin
         exp_q.push_back({yl, d});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int c0, p0;
      reset = 1'b0; in_valid = 1'b0; FS = 5'd0; dest = 5'd0; Y_hi = 32'd0; Y_lo = 32'd0;
      {C, V, N, Z} = 4'b0000; wb_ready = 1'b0; clr_sticky = 1'b0;
      #12;
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_hi", hi_q, 32'd0);
      check("rst_lo", lo_q, 32'd0);
      check("rst_flags", 32'(flags_q), 32'd0);
      check("rst_sticky", 32'(sticky_v), 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Establish C=1, then multiply: C/V must hold, N/Z update.
      send(5'h02, 5'd0, 32'd0, 32'h5, 4'b1000);
      idle(1);
      check("pre_mul_flags", 32'(flags_q), 32'h8);
      send(5'h1E, 5'd9, 32'h1, 32'hFFFF_FFFE, 4'b0010);
      in_valid = 1'b0;
      check("mul_hi", hi_q, 32'h1);
      check("mul_lo", lo_q, 32'hFFFF_FFFE);
      check("mul_no_wb", 32'(wb_valid), 32'd0);
      check("mul_flags", 32'(flags_q), 32'hA);

      // dest 0: data discarded, all flags update.
      send(5'h03, 5'd0, 32'd0, 32'h0, 4'b0001);
      in_valid = 1'b0;
      check("d0_no_wb", 32'(wb_valid), 32'd0);
      check("d0_flags", 32'(flags_q), 32'h1);
      check("d0_hold_hi", hi_q, 32'h1);

      // Fill, then offer a third item while draining; it waits one cycle.
      wb_ready = 1'b0;
      send(5'h04, 5'd5, 32'd0, 32'hA, 4'b0000);
      send(5'h04, 5'd6, 32'd0, 32'hB, 4'b0000);
      in_valid = 1'b0;
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_head", wb_data, 32'hA);
      FS = 5'h04; dest = 5'd7; Y_lo = 32'hC; in_valid = 1'b1; wb_ready = 1'b1;
      @(negedge clk);
      check("full_block", 32'(in_ready), 32'd0);
      send(5'h04, 5'd7, 32'd0, 32'hC, 4'b0000);
      idle(4);
      check("wrap_drained", 32'(wb_valid), 32'd0);
      check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

      // Back-to-back throughput with wb_ready held high.
      c0 = cycles; p0 = pops;
      for (int i = 0; i < 8; i++) begin
         send(5'h00, 5'(i + 1), 32'd0, 32'h100 + 32'(i), 4'b0000);
         check("tp_latency", 32'(wb_valid), 32'd1);
      end
      check("tp_cycles", 32'(cycles - c0), 32'd8);
      idle(3);
      check("tp_pops", 32'(pops - p0), 32'd8);

      // Sticky overflow behaviour.
      send(5'h01, 5'd0, 32'd0, 32'd0, 4'b0100);
      in_valid = 1'b0;
`ifdef STICKY_V_EN
      check("sticky_set", 32'(sticky_v), 32'd1);
      send(5'h01, 5'd0, 32'd0, 32'd0, 4'b0000);
      in_valid = 1'b0;
      check("sticky_hold", 32'(sticky_v), 32'd1);
      clr_sticky = 1'b1;
      @(posedge clk); #1;
      clr_sticky = 1'b0;
      check("sticky_clr", 32'(sticky_v), 32'd0);
      clr_sticky = 1'b1;
      send(5'h01, 5'd0, 32'd0, 32'd0, 4'b0100);
      in_valid = 1'b0; clr_sticky = 1'b0;
      check("sticky_set_wins", 32'(sticky_v), 32'd1);
`else
      check("sticky_off", 32'(sticky_v), 32'd0);
`endif

      // Asynchronous reset while entries are pending.
      send(5'h1F, 5'd1, 32'h77, 32'h88, 4'b0000);
      wb_ready = 1'b0;
      send(5'h04, 5'd3, 32'd0, 32'h11, 4'b0000);
      send(5'h04, 5'd4, 32'd0, 32'h22, 4'b0000);
      in_valid = 1'b0;
      check("pre_rst_full", 32'(in_ready), 32'd0);
      check("pre_rst_hi", hi_q, 32'h77);
      #2 reset = 1'b0;
      #1;
      check("arst_wb_valid", 32'(wb_valid), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_hi", hi_q, 32'd0);
      check("arst_lo", lo_q, 32'd0);
      check("arst_wb_data", wb_data, 32'd0);
      exp_q.delete();
      @(posedge clk); #2 reset = 1'b1;
      wb_ready = 1'b1;
      @(posedge clk); #1;
      check("post_rst_idle", 32'(wb_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
